// File: rtl/grid_pkg.sv
// Shared playfield types and constants for the frame-write and line-clear stages.
package grid_pkg;

    localparam int ROWS   = 20;
    localparam int COLS   = 10;
    localparam int CELL_W = 3;

    // Row index width and lines-cleared width (must hold ROWS itself).
    localparam int ROW_W = $clog2(ROWS);
    localparam int LC_W  = $clog2(ROWS + 1);

    typedef logic [CELL_W-1:0]   cell_t;
    typedef cell_t [COLS-1:0]    row_t;
    typedef row_t  [ROWS-1:0]    grid_t;

    localparam cell_t EMPTY     = '0;
    localparam row_t  EMPTY_ROW = '0;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        SHIFT,
        DONE
    } lc_state_t;

endpackage

// File: rtl/line_clear_if.sv
// Handshake and grid bus between the write-back stage and the line-clear stage.
interface line_clear_if #(
    parameter int TOT_W = 16
);
    import grid_pkg::*;

    logic              start;
    grid_t             grid_in;
    grid_t             grid_out;
    logic              busy;
    logic              done;
    logic [LC_W-1:0]   lines_cleared;
    logic [TOT_W-1:0]  total_lines;

    modport master (
        output start, grid_in,
        input  grid_out, busy, done, lines_cleared, total_lines
    );

    modport slave (
        input  start, grid_in,
        output grid_out, busy, done, lines_cleared, total_lines
    );

endinterface

// File: rtl/line_clear_row_full.sv
// Combinational test: a row is full when every one of its cells is non-EMPTY.
module row_full
    import grid_pkg::*;
(
    input  row_t row,
    output logic full
);

    // AND-reduce of per-cell occupancy across the row.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        full = 1'b1;
        for (int c = 0; c < COLS; c++) begin
            if (row[c] == EMPTY) begin
                full = 1'b0;
            end
        end
    end

endmodule

// File: rtl/line_clear.sv
// Line-clear stage: scans the working grid bottom-up, removes full rows by shifting
// everything above down one row, and reports per-pass and running line counts.
module line_clear
    import grid_pkg::*;
#(
    parameter int TOT_W = 16
)
(
    input  logic          clk,
    input  logic          rst_n,
    line_clear_if.slave   bus
);

    // Wide enough to hold the unsaturated sum of either operand width.
    localparam int SUM_W = ((TOT_W > LC_W) ? TOT_W : LC_W) + 1;

    lc_state_t         state, state_nx;
    grid_t             grid_q;
    logic [ROW_W-1:0]  row_idx;
    logic [LC_W-1:0]   lc_q;
    logic [TOT_W-1:0]  total_q;
    logic [TOT_W-1:0]  total_sat;
    logic [SUM_W-1:0]  sum;
    logic              row_is_full;

    row_full u_row_full (
        .row  (grid_q[row_idx]),
        .full (row_is_full)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode; start only matters while idle.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = SCAN;
            SCAN:    begin
                         if (row_is_full)          state_nx = SHIFT;
                         else if (row_idx == '0)   state_nx = DONE;
                     end
            SHIFT:   state_nx = SCAN;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Saturating add of this pass's lines into the running total.
    always_comb begin
        sum = SUM_W'(total_q) + SUM_W'(lc_q);
        if (sum > SUM_W'({TOT_W{1'b1}})) begin
            total_sat = {TOT_W{1'b1}};
        end else begin
            total_sat = sum[TOT_W-1:0];
        end
    end

    // Working grid, scan index and line counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the grid storage is reset because downstream reads grid_out as an all-EMPTY field after reset.
            grid_q  <= '0;
            row_idx <= ROW_W'(ROWS - 1);
            lc_q    <= '0;
            total_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        grid_q  <= bus.grid_in;
                        row_idx <= ROW_W'(ROWS - 1);
                        lc_q    <= '0;
                    end
                end
                SCAN: begin
                    if (!row_is_full && row_idx != '0) begin
                        row_idx <= row_idx - 1'b1;
                    end
                end
                SHIFT: begin
                    // Rows 1..row_idx take the row above; rows below row_idx are untouched.
                    for (int i = 1; i < ROWS; i++) begin
                        if (ROW_W'(i) <= row_idx) begin
                            grid_q[i] <= grid_q[i-1];
                        end
                    end
                    grid_q[0] <= EMPTY_ROW;
                    lc_q      <= lc_q + 1'b1;
                end
                DONE: begin
                    total_q <= total_sat;
                end
                default: ;
            endcase
        end
    end

    assign bus.grid_out      = grid_q;
    assign bus.busy          = (state != IDLE);
    assign bus.done          = (state == DONE);
    assign bus.lines_cleared = lc_q;
    assign bus.total_lines   = total_q;

endmodule

// File: tb/tb_line_clear.sv
// Self-checking bench for line_clear: a pass-level reference model predicts the
// cleared grid, line count, done timing and saturating totals, compared every cycle.
module tb_line_clear;
    import grid_pkg::*;

    localparam int GW      = ROWS * COLS * CELL_W;
    localparam int SMALL_W = 4;

    logic clk;
    logic rst_n;

    line_clear_if #(.TOT_W(16))      bus   ();
    line_clear_if #(.TOT_W(SMALL_W)) bus_s ();

    assign bus_s.start   = bus.start;
    assign bus_s.grid_in = bus.grid_in;

    line_clear #(.TOT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    line_clear #(.TOT_W(SMALL_W)) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [GW-1:0] act, input logic [GW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit is_full(input row_t r);
        for (int c = 0; c < COLS; c++) if (r[c] == EMPTY) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int count_full(input grid_t g);
        int k = 0;
        for (int r = 0; r < ROWS; r++) if (is_full(g[r])) k++;
        return k;
    endfunction

    // Surviving rows keep their order and settle at the bottom; the top fills with EMPTY.
    function automatic grid_t clear_grid(input grid_t g);
        grid_t o = '0;
        int w = ROWS - 1;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (!is_full(g[r])) begin
                o[w] = g[r];
                w--;
            end
        end
        return o;
    endfunction

    function automatic int sat(input int a, input int b, input int maxv);
        return (a + b > maxv) ? maxv : a + b;
    endfunction

    bit    m_busy, m_done;
    int    m_cnt, m_k, m_lc, m_total, m_total_s;
    grid_t m_grid, m_final;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy    <= 1'b0;
            m_done    <= 1'b0;
            m_cnt     <= 0;
            m_k       <= 0;
            m_lc      <= 0;
            m_total   <= 0;
            m_total_s <= 0;
            m_grid    <= '0;
            m_final   <= '0;
        end else begin
            m_done <= 1'b0;
            if (!m_busy) begin
                if (bus.start === 1'b1) begin
                    m_busy  <= 1'b1;
                    m_k     <= count_full(bus.grid_in);
                    m_cnt   <= ROWS + 2 * count_full(bus.grid_in);
                    m_final <= clear_grid(bus.grid_in);
                    m_lc    <= 0;
                end
            end else if (m_done) begin
                m_busy    <= 1'b0;
                m_total   <= sat(m_total, m_k, 65535);
                m_total_s <= sat(m_total_s, m_k, (1 << SMALL_W) - 1);
            end else begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_done <= 1'b1;
                    m_lc   <= m_k;
                    m_grid <= m_final;
                end
            end
        end
    end

    // Cycle-by-cycle comparison; grid and line count only when they are defined.
    always @(negedge clk) begin
        if (rst_n) begin
            check("busy",    GW'(bus.busy),          GW'(m_busy));
            check("done",    GW'(bus.done),          GW'(m_done));
            check("total",   GW'(bus.total_lines),   GW'(m_total));
            check("done_s",  GW'(bus_s.done),        GW'(m_done));
            check("total_s", GW'(bus_s.total_lines), GW'(m_total_s));
            if (!m_busy || m_done) begin
                check("grid_out",      GW'(bus.grid_out),      GW'(m_grid));
                check("lines_cleared", GW'(bus.lines_cleared), GW'(m_lc));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic row_t fill_row(input int colour);
        row_t r;
        for (int c = 0; c < COLS; c++) r[c] = cell_t'(colour);
        return r;
    endfunction

    function automatic row_t pattern_row(input int seed);
        row_t r;
        for (int c = 0; c < COLS; c++) r[c] = cell_t'((c + seed) % 8);
        return r;
    endfunction

    function automatic grid_t rand_grid();
        grid_t g;
        int mode;
        for (int r = 0; r < ROWS; r++) begin
            mode = $urandom_range(0, 3);
            for (int c = 0; c < COLS; c++) begin
                case (mode)
                    0, 3:    g[r][c] = cell_t'($urandom_range(1, 7));
                    1:       g[r][c] = cell_t'($urandom_range(0, 7));
                    default: g[r][c] = EMPTY;
                endcase
            end
        end
        return g;
    endfunction

    // One pass: pulse start, wait (bounded) for done, optionally re-pulse start while busy and in DONE.
    // lat counts edges from the start-sampling edge to the first edge at which done is high.
    task automatic do_pass(input grid_t g, input bit repulse, output int lat);
        int n = 0;
        @(negedge clk);
        bus.grid_in = g;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start   = 1'b0;
        while (bus.done !== 1'b1 && n < 200) begin
            bus.start = repulse && (n == 4);
            @(negedge clk);
            n++;
        end
        bus.start = 1'b0;
        lat = n + 1;
        if (n >= 200) check("done_timeout", GW'(0), GW'(1));
        if (repulse) begin
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
            check("single_done_pulse", GW'(bus.done), GW'(0));
            check("idle_after_done",   GW'(bus.busy), GW'(0));
        end else begin
            @(negedge clk);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        grid_t g;
        row_t  marker, row_a, row_b, row_c;
        int    lat, t_before;

        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.grid_in = '0;
        repeat (3) @(negedge clk);
        check("rst_busy",  GW'(bus.busy),          GW'(0));
        check("rst_done",  GW'(bus.done),          GW'(0));
        check("rst_grid",  GW'(bus.grid_out),      GW'(0));
        check("rst_lc",    GW'(bus.lines_cleared), GW'(0));
        check("rst_total", GW'(bus.total_lines),   GW'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // 1: empty grid
        do_pass('0, 1'b0, lat);
        check("t1_latency", GW'(lat),               GW'(21));
        check("t1_lc",      GW'(bus.lines_cleared), GW'(0));
        check("t1_grid",    GW'(bus.grid_out),      GW'(0));

        // 2: row 19 full, row 18 partial
        g      = '0;
        g[19]  = fill_row(3);
        g[18]  = fill_row(5);
        g[18][0] = EMPTY;
        row_a  = g[18];
        do_pass(g, 1'b0, lat);
        check("t2_latency", GW'(lat),                GW'(23));
        check("t2_lc",      GW'(bus.lines_cleared),  GW'(1));
        check("t2_row19",   GW'(bus.grid_out[19]),   GW'(row_a));
        check("t2_row18",   GW'(bus.grid_out[18]),   GW'(EMPTY_ROW));
        check("t2_row0",    GW'(bus.grid_out[0]),    GW'(EMPTY_ROW));

        // 3: rows 19..16 full, marker in row 15
        g = '0;
        for (int r = 16; r < 20; r++) g[r] = fill_row((r % 7) + 1);
        marker = pattern_row(0);
        g[15]  = marker;
        do_pass(g, 1'b0, lat);
        check("t3_latency", GW'(lat),               GW'(29));
        check("t3_lc",      GW'(bus.lines_cleared), GW'(4));
        check("t3_row19",   GW'(bus.grid_out[19]),  GW'(marker));
        for (int r = 0; r < 16; r++) check("t3_empty_row", GW'(bus.grid_out[r]), GW'(EMPTY_ROW));
        check("t3_total",   GW'(bus.total_lines),   GW'(5));

        // 4: non-adjacent full rows 19 and 17
        g      = '0;
        row_a  = pattern_row(1);
        row_b  = pattern_row(3);
        row_c  = pattern_row(6);
        g[19]  = fill_row(1);
        g[18]  = row_a;
        g[17]  = fill_row(2);
        g[16]  = row_b;
        g[15]  = row_c;
        t_before = int'(bus.total_lines);
        do_pass(g, 1'b0, lat);
        check("t4_latency", GW'(lat),                       GW'(25));
        check("t4_lc",      GW'(bus.lines_cleared),         GW'(2));
        check("t4_row19",   GW'(bus.grid_out[19]),          GW'(row_a));
        check("t4_row18",   GW'(bus.grid_out[18]),          GW'(row_b));
        check("t4_row17",   GW'(bus.grid_out[17]),          GW'(row_c));
        check("t4_row16",   GW'(bus.grid_out[16]),          GW'(EMPTY_ROW));
        check("t4_delta",   GW'(int'(bus.total_lines) - t_before), GW'(2));

        // 6: all-full grid, start re-pulsed while busy and during DONE; narrow total saturates
        for (int r = 0; r < ROWS; r++) g[r] = fill_row((r % 7) + 1);
        do_pass(g, 1'b1, lat);
        check("t6_latency", GW'(lat),                 GW'(61));
        check("t6_lc",      GW'(bus.lines_cleared),   GW'(20));
        check("t6_grid",    GW'(bus.grid_out),        GW'(0));
        check("t6_total",   GW'(bus.total_lines),     GW'(27));
        check("t6_total_s", GW'(bus_s.total_lines),   GW'(15));

        // 5: reset while in SHIFT
        g     = '0;
        g[19] = fill_row(4);
        @(negedge clk);
        bus.grid_in = g;
        bus.start   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start   = 1'b0;
        @(posedge clk);
        #2;
        check("t5_busy_before", GW'(bus.busy), GW'(1));
        rst_n = 1'b0;
        #1;
        check("t5_busy",  GW'(bus.busy),          GW'(0));
        check("t5_done",  GW'(bus.done),          GW'(0));
        check("t5_grid",  GW'(bus.grid_out),      GW'(0));
        check("t5_lc",    GW'(bus.lines_cleared), GW'(0));
        check("t5_total", GW'(bus.total_lines),   GW'(0));
        @(negedge clk);
        rst_n = 1'b1;
        do_pass(g, 1'b0, lat);
        check("t5_latency", GW'(lat),               GW'(23));
        check("t5_lc_after", GW'(bus.lines_cleared), GW'(1));
        check("t5_total_after", GW'(bus.total_lines), GW'(1));

        // Randomized passes against the model.
        for (int p = 0; p < 40; p++) begin
            g = rand_grid();
            do_pass(g, ($urandom_range(0, 3) == 0), lat);
            check("rand_latency", GW'(lat), GW'(ROWS + 1 + 2 * count_full(g)));
        end

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
